// File: rtl/mem_arbiter.sv
// Shares one main-memory read port between the I-cache and D-cache, filling
// 16-byte blocks (eight 16-bit words) with D-cache priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        icache_write,
  output logic        dcache_write,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_q, issue_d;
  logic [2:0]  recv_q, recv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    base_d           = base_q;
    issue_d          = issue_q;
    recv_d           = recv_q;
    mem_enable       = 1'b0;
    mem_addr         = '0;
    fill_data        = '0;
    fill_word        = '0;
    icache_write     = 1'b0;
    dcache_write     = 1'b0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (dcache_miss) begin
          state_d = FILL;
          grant_d = 1'b1;
          base_d  = dcache_addr & 16'hFFF0;
          issue_d = '0;
          recv_d  = '0;
        end else if (icache_miss) begin
          state_d = FILL;
          grant_d = 1'b0;
          base_d  = icache_addr & 16'hFFF0;
          issue_d = '0;
          recv_d  = '0;
        end
      end
      FILL: begin
        // issue_q[3] marks all eight requests sent; base low nibble is zero
        if (!issue_q[3]) begin
          mem_enable = 1'b1;
          mem_addr   = base_q | {12'b0, issue_q[2:0], 1'b0};
          issue_d    = issue_q + 4'd1;
        end
        if (mem_data_valid) begin
          fill_data    = mem_data_in;
          fill_word    = recv_q;
          icache_write = ~grant_q;
          dcache_write = grant_q;
          recv_d       = recv_q + 3'd1;
          if (recv_q == 3'd7) state_d = DONE;
        end
      end
      DONE: begin
        icache_fill_done = ~grant_q;
        dcache_fill_done = grant_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = (state_q != IDLE) | icache_miss | dcache_miss;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized miss
// patterns, checked against a transaction-level fill schedule.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss;
  logic [15:0] icache_addr, dcache_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_enable;
  logic [15:0] mem_addr;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        icache_write, dcache_write;
  logic        icache_fill_done, dcache_fill_done;
  logic        mem_stall;

  logic        mv, stray;
  logic [15:0] md;
  assign mem_data_valid = mv | stray;
  assign mem_data_in    = stray ? 16'hBEEF : md;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_addr(mem_addr),
    .fill_data(fill_data), .fill_word(fill_word),
    .icache_write(icache_write), .dcache_write(dcache_write),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [15:0] addr; int cyc; } req_t;
  typedef struct { bit dc; logic [2:0] word; logic [15:0] data; int cyc; } wr_t;
  typedef struct { bit dc; int cyc; } done_t;

  req_t  req_q[$];
  wr_t   wr_q[$];
  done_t done_q[$];
  req_t  mpipe[$];

  logic [15:0] mem_img [0:32767];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected transactions of one block fill whose first request lands in cycle s
  task automatic schedule(input bit dc, input logic [15:0] a, input int s);
    req_t  r;
    wr_t   w;
    done_t d;
    logic [15:0] base;
    base = {a[15:4], 4'b0000};
    for (int i = 0; i < 8; i++) begin
      r.addr = base + 16'(2 * i);
      r.cyc  = s + i;
      req_q.push_back(r);
      w.dc   = dc;
      w.word = 3'(i);
      w.data = mem_img[r.addr[15:1]];
      w.cyc  = s + 4 + i;
      wr_q.push_back(w);
    end
    d.dc  = dc;
    d.cyc = s + 12;
    done_q.push_back(d);
  endtask

  // Main memory: fixed 4-cycle in-order latency, junk on the bus when idle
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mpipe.delete();
      mv = 1'b0;
    end else if (mpipe.size() != 0 && mpipe[0].cyc == cyc) begin
      mv = 1'b1;
      md = mem_img[mpipe[0].addr[15:1]];
      void'(mpipe.pop_front());
    end else begin
      mv = 1'b0;
      md = 16'($urandom);
    end
  end

  // Monitor: compares every DUT event against the scoreboard queues
  always @(negedge clk) begin
    req_t  r;
    wr_t   w;
    done_t d;
    check("mem_stall", {31'b0, mem_stall},
          {31'b0, icache_miss | dcache_miss | (done_q.size() != 0)});
    while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
      check("req_missing_cycle", cyc, req_q[0].cyc);
      void'(req_q.pop_front());
    end
    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      check("write_missing_cycle", cyc, wr_q[0].cyc);
      void'(wr_q.pop_front());
    end
    while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      check("done_missing_cycle", cyc, done_q[0].cyc);
      void'(done_q.pop_front());
    end

    if (mem_enable) begin
      if (req_q.size() == 0) check("req_unexpected", {16'b0, mem_addr}, 32'hFFFF_FFFF);
      else begin
        r = req_q.pop_front();
        check("req_addr", {16'b0, mem_addr}, {16'b0, r.addr});
        check("req_cycle", cyc, r.cyc);
      end
      r.addr = mem_addr;
      r.cyc  = cyc + 4;
      mpipe.push_back(r);
    end

    if (icache_write && dcache_write) check("both_writes", 1, 0);
    else if (icache_write || dcache_write) begin
      if (wr_q.size() == 0) check("write_unexpected", 1, 0);
      else begin
        w = wr_q.pop_front();
        check("write_cache_d", {31'b0, dcache_write}, {31'b0, w.dc});
        check("fill_word", {29'b0, fill_word}, {29'b0, w.word});
        check("fill_data", {16'b0, fill_data}, {16'b0, w.data});
        check("write_cycle", cyc, w.cyc);
      end
    end else begin
      check("quiet_fill_data", {16'b0, fill_data}, 0);
      check("quiet_fill_word", {29'b0, fill_word}, 0);
    end

    if (icache_fill_done && dcache_fill_done) check("both_dones", 1, 0);
    else if (icache_fill_done || dcache_fill_done) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        check("done_cache_d", {31'b0, dcache_fill_done}, {31'b0, d.dc});
        check("done_cycle", cyc, d.cyc);
      end
      // requester drops its miss during the DONE cycle
      if (dcache_fill_done) dcache_miss = 1'b0;
      else icache_miss = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input bit dc, input logic [15:0] a);
    if (dc) begin
      dcache_addr = a;
      dcache_miss = 1'b1;
    end else begin
      icache_addr = a;
      icache_miss = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_enable"}, {31'b0, mem_enable}, 0);
    check({tag, "_mem_addr"}, {16'b0, mem_addr}, 0);
    check({tag, "_fill_data"}, {16'b0, fill_data}, 0);
    check({tag, "_fill_word"}, {29'b0, fill_word}, 0);
    check({tag, "_writes"}, {30'b0, icache_write, dcache_write}, 0);
    check({tag, "_dones"}, {30'b0, icache_fill_done, dcache_fill_done}, 0);
  endtask

  task automatic finish_up();
    check("leftover_expected", req_q.size() + wr_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((done_q.size() != 0 || icache_miss || dcache_miss) && n < 400);
    if (done_q.size() != 0 || icache_miss || dcache_miss) begin
      check("fill_timeout_cycles", n, 0);
      finish_up();
    end
  endtask

  initial begin
    int          kind, off, c0, gap;
    bit          first;
    logic [15:0] a0, a1;

    for (int i = 0; i < 32768; i++) mem_img[i] = 16'($urandom);
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0;
    icache_addr = '0;   dcache_addr = '0;
    mv = 1'b0; md = '0; stray = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    check("reset_mem_stall", {31'b0, mem_stall}, 0);
    step();
    rst = 1'b0;

    // stray valid while idle must not write or move the receive count
    step();
    stray = 1'b1;
    @(negedge clk);
    check("stray_writes", {30'b0, icache_write, dcache_write}, 0);
    check("stray_fill_data", {16'b0, fill_data}, 0);
    step();
    stray = 1'b0;
    step();

    // single D miss at 0x1234
    raise(1'b1, 16'h1234);
    schedule(1'b1, 16'h1234, cyc + 1);
    wait_idle();

    // simultaneous misses: D first, then I
    raise(1'b1, 16'h8008);
    raise(1'b0, 16'h0040);
    schedule(1'b1, 16'h8008, cyc + 1);
    schedule(1'b0, 16'h0040, cyc + 15);
    wait_idle();

    // I miss raised mid D fill waits for the D fill to finish
    c0 = cyc;
    raise(1'b1, 16'h4E6A);
    schedule(1'b1, 16'h4E6A, c0 + 1);
    repeat (5) step();
    raise(1'b0, 16'h00F2);
    schedule(1'b0, 16'h00F2, c0 + 15);
    wait_idle();

    // D miss dropped after two requests: fill still completes
    raise(1'b1, 16'h2D5C);
    schedule(1'b1, 16'h2D5C, cyc + 1);
    repeat (3) step();
    dcache_miss = 1'b0;
    wait_idle();

    // reset after three words received discards the fill
    c0 = cyc;
    raise(1'b1, 16'hA5A6);
    schedule(1'b1, 16'hA5A6, c0 + 1);
    repeat (8) step();
    #1;
    rst = 1'b1;
    dcache_miss = 1'b0;
    req_q.delete(); wr_q.delete(); done_q.delete(); mpipe.delete();
    mv = 1'b0;
    @(negedge clk);
    check_outputs_zero("midfill_reset");
    step();
    step();
    rst = 1'b0;
    step();
    raise(1'b1, 16'h3339);
    schedule(1'b1, 16'h3339, cyc + 1);
    wait_idle();

    // randomized miss patterns
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 3);
      a0    = 16'($urandom);
      a1    = 16'($urandom);
      first = 1'($urandom_range(0, 1));
      off   = $urandom_range(1, 13);
      c0    = cyc;
      case (kind)
        0: begin raise(1'b1, a0); schedule(1'b1, a0, c0 + 1); end
        1: begin raise(1'b0, a0); schedule(1'b0, a0, c0 + 1); end
        2: begin
          raise(1'b1, a0);
          raise(1'b0, a1);
          schedule(1'b1, a0, c0 + 1);
          schedule(1'b0, a1, c0 + 15);
        end
        default: begin
          raise(first, a0);
          schedule(first, a0, c0 + 1);
          repeat (off) step();
          raise(!first, a1);
          schedule(!first, a1, c0 + 15);
        end
      endcase
      wait_idle();
      gap = $urandom_range(0, 3);
      repeat (gap) step();
    end

    step();
    finish_up();
  end
endmodule
